systolic_array_top: RTL and testbench



---
 rtl/systolic_pkg.sv | 27 ++
 rtl/systolic_array_top_pe.sv | 44 ++++
 rtl/systolic_array_top.sv | 165 ++++++++++++++++
 tb/tb_systolic_array_top.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the output-stationary systolic
// matrix-multiply engine.
//   state_t       : controller states
//   DEF_*         : default operand / accumulator / grid dimensions
//   DRAIN_CNT     : cycles from the first idle cycle after the stream until
//                   the far-corner PE has made its last accumulate
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_ROWS   = 4;
    localparam int DEF_COLS   = 4;

    localparam int DRAIN_CNT  = DEF_ROWS + DEF_COLS - 1;

    function automatic int drain_count(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/systolic_array_top_pe.sv
// One processing element of the systolic grid.
//   clk, reset_n  : clock, synchronous active-low reset
//   clear         : zero the accumulator (start of a new operation)
//   enable        : accumulate a_in * b_in this cycle
//   a_in / a_out  : A operand entering from the left, registered to the right
//   b_in / b_out  : B operand entering from above, registered downward
//   acc           : running signed sum, wraps modulo 2^ACC_W
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;

    // Widen both operands first so the multiply is done at full product width.
    assign prod = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            if (clear) begin
                acc <= '0;
            end else if (enable) begin
                acc <= acc + ACC_W'(prod);
            end
        end
    end

endmodule

// File: rtl/systolic_array_top.sv
// Output-stationary signed matrix multiply: C = A x B on a ROWS x COLS PE grid.
// A arrives one column per beat, B one row per beat; a beat is a cycle with
// both valids high. After the stream ends the array drains and the completed
// product is registered onto result_matrix with done/result_valid held high.
//   clk, reset_n       : clock, synchronous active-low reset
//   matrix_acc_col     : A[i][k] for i = 0..ROWS-1, qualified by matrix_acc_valid
//   matrix_wet_row     : B[k][j] for j = 0..COLS-1, qualified by matrix_wet_valid
//   result_matrix      : C[i][j], stable while result_valid is high
//   done, result_valid : completion levels, cleared by reset or the next first beat
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | no operation since reset, waiting for a first beat
// COMPUTE | accepting contiguous beats
// DRAIN   | stream ended, flushing products through the grid
// DONE    | result presented, a new beat starts the next operation
module systolic_array_top
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     done,
    input  logic signed [DATA_W-1:0] matrix_acc_col [ROWS],
    input  logic                     matrix_acc_valid,
    input  logic signed [DATA_W-1:0] matrix_wet_row [COLS],
    input  logic                     matrix_wet_valid,
    output logic signed [ACC_W-1:0]  result_matrix [ROWS][COLS],
    output logic                     result_valid
);

    localparam int DRAIN_LEN = drain_count(ROWS, COLS);
    localparam int CNT_W     = $clog2(DRAIN_LEN + 1);

    state_t           state;
    logic [CNT_W-1:0] drain_cnt;

    logic beat;
    logic accept;
    logic start;
    logic mac_en;

    logic signed [DATA_W-1:0] a_skew_out [ROWS];
    logic signed [DATA_W-1:0] b_skew_out [COLS];
    logic signed [DATA_W-1:0] a_link     [ROWS][COLS];
    logic signed [DATA_W-1:0] b_link     [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc_grid   [ROWS][COLS];

    assign beat   = matrix_acc_valid && matrix_wet_valid;
    // Beats seen while draining are dropped so they cannot pollute the result.
    assign accept = beat && (state != DRAIN);
    assign start  = beat && ((state == IDLE) || (state == DONE));
    assign mac_en = (state == COMPUTE) || (state == DRAIN);

    // Row i is delayed i extra cycles so that A[i][k] and B[k][j] coincide at
    // PE(i,j) on edge t+i+j+1. Non-accepted cycles inject zeros.
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        logic signed [DATA_W-1:0] sr [i+1];
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int k = 0; k <= i; k++) sr[k] <= '0;
            end else begin
                sr[0] <= accept ? matrix_acc_col[i] : '0;
                for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
            end
        end
        assign a_skew_out[i] = sr[i];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        logic signed [DATA_W-1:0] sr [j+1];
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int k = 0; k <= j; k++) sr[k] <= '0;
            end else begin
                sr[0] <= accept ? matrix_wet_row[j] : '0;
                for (int k = 1; k <= j; k++) sr[k] <= sr[k-1];
            end
        end
        assign b_skew_out[j] = sr[j];
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic signed [DATA_W-1:0] a_src;
            logic signed [DATA_W-1:0] b_src;

            if (j == 0) begin : g_a_edge
                assign a_src = a_skew_out[i];
            end else begin : g_a_inner
                assign a_src = a_link[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_src = b_skew_out[j];
            end else begin : g_b_inner
                assign b_src = b_link[i-1][j];
            end

            systolic_pe #(
                .DATA_W(DATA_W),
                .ACC_W (ACC_W)
            ) u_pe (
                .clk    (clk),
                .reset_n(reset_n),
                .clear  (start),
                .enable (mac_en),
                .a_in   (a_src),
                .b_in   (b_src),
                .a_out  (a_link[i][j]),
                .b_out  (b_link[i][j]),
                .acc    (acc_grid[i][j])
            );
        end
    end

    // Drain is loaded on the first non-beat edge and expires so that the
    // result is captured exactly ROWS+COLS edges after the last beat.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    result_matrix[i][j] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) state <= COMPUTE;
                end
                COMPUTE: begin
                    if (!beat) begin
                        state     <= DRAIN;
                        drain_cnt <= CNT_W'(DRAIN_LEN - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        result_valid  <= 1'b1;
                        result_matrix <= acc_grid;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (beat) begin
                        state        <= COMPUTE;
                        done         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_array_top.sv
module tb_systolic_array_top;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int NTBL = 7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic done;
    logic signed [7:0]  acc_col [ROWS];
    logic               acc_valid = 1'b0;
    logic signed [7:0]  wet_row [COLS];
    logic               wet_valid = 1'b0;
    logic signed [31:0] result [ROWS][COLS];
    logic               result_valid;

    always #5 clk = ~clk;

    systolic_array_top dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .done            (done),
        .matrix_acc_col  (acc_col),
        .matrix_acc_valid(acc_valid),
        .matrix_wet_row  (wet_row),
        .matrix_wet_valid(wet_valid),
        .result_matrix   (result),
        .result_valid    (result_valid)
    );

    typedef struct packed {
        logic [3:0]                    k;
        logic [1:0]                    pre;
        logic signed [3:0][3:0][7:0]   a;   // a[i][k]
        logic signed [3:0][3:0][7:0]   b;   // b[k][j]
        logic signed [3:0][3:0][31:0]  c;   // c[i][j]
    } vec_t;

    vec_t tbl [NTBL];

    int n_vec  = 0;
    int n_fail = 0;
    int cur_a [ROWS][16];
    int cur_b [16][COLS];
    int exp_c [ROWS][COLS];

    task automatic chk(input string nm, input longint act, input longint expv);
        n_vec++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Plain matrix product; int arithmetic wraps modulo 2^32 like the accumulators.
    task automatic model(input int k);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                exp_c[i][j] = 0;
                for (int s = 0; s < k; s++) exp_c[i][j] += cur_a[i][s] * cur_b[s][j];
            end
    endtask

    task automatic check_result(input string tag);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                chk($sformatf("%s c[%0d][%0d]", tag, i, j), longint'(result[i][j]), longint'(exp_c[i][j]));
    endtask

    task automatic run_op(input string tag, input int k, input int pre, input bit drop, input bit junk);
        int  lat;
        bit  seen;
        for (int n = 0; n < pre; n++) begin
            for (int i = 0; i < ROWS; i++) acc_col[i] = 8'($urandom);
            for (int j = 0; j < COLS; j++) wet_row[j] = 8'($urandom);
            acc_valid = 1'b1;
            wet_valid = 1'b0;
            @(negedge clk);
        end
        for (int s = 0; s < k; s++) begin
            for (int i = 0; i < ROWS; i++) acc_col[i] = 8'(cur_a[i][s]);
            for (int j = 0; j < COLS; j++) wet_row[j] = 8'(cur_b[s][j]);
            acc_valid = 1'b1;
            wet_valid = 1'b1;
            @(posedge clk);
            #1;
            if (s == 0 && drop) begin
                chk({tag, " done_drop"}, longint'(done), 0);
                chk({tag, " rv_drop"}, longint'(result_valid), 0);
            end
            @(negedge clk);
        end
        acc_valid = 1'b0;
        wet_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = n;
            end else if (junk && n <= 3) begin
                for (int i = 0; i < ROWS; i++) acc_col[i] = 8'($urandom);
                for (int j = 0; j < COLS; j++) wet_row[j] = 8'($urandom);
                acc_valid = 1'b1;
                wet_valid = 1'b1;
            end else begin
                acc_valid = 1'b0;
                wet_valid = 1'b0;
            end
        end
        acc_valid = 1'b0;
        wet_valid = 1'b0;
        chk({tag, " latency"}, longint'(lat), longint'(ROWS + COLS));
        chk({tag, " result_valid"}, longint'(result_valid), 1);
        check_result(tag);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < ROWS; i++) acc_col[i] = '0;
        for (int j = 0; j < COLS; j++) wet_row[j] = '0;

        for (int v = 0; v < NTBL; v++) tbl[v] = '0;
        // 2x2 embedded in 4x4, clean and with three mismatched-valid cycles ahead
        tbl[0].k = 4;
        tbl[0].a[0][0] = 8'sd1; tbl[0].a[0][1] = 8'sd2; tbl[0].a[1][0] = 8'sd3; tbl[0].a[1][1] = 8'sd4;
        tbl[0].b[0][0] = 8'sd5; tbl[0].b[0][1] = 8'sd6; tbl[0].b[1][0] = 8'sd7; tbl[0].b[1][1] = 8'sd8;
        tbl[0].c[0][0] = 32'sd19; tbl[0].c[0][1] = 32'sd22; tbl[0].c[1][0] = 32'sd43; tbl[0].c[1][1] = 32'sd50;
        tbl[1] = tbl[0];
        tbl[1].pre = 3;
        tbl[2].k = 4; tbl[3].k = 4; tbl[4].k = 4; tbl[5].k = 4; tbl[6].k = 1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                tbl[2].a[i][j] = -8'sd128; tbl[2].b[i][j] = -8'sd128; tbl[2].c[i][j] = 32'sd65536;
                tbl[3].a[i][j] = 8'sd127;  tbl[3].b[i][j] = -8'sd128; tbl[3].c[i][j] = -32'sd65024;
                tbl[4].a[i][j] = (i == j) ? 8'sd1 : 8'sd0;
                tbl[5].a[i][j] = (i == j) ? 8'sd2 : 8'sd0;
                tbl[4].b[i][j] = 8'(4 * i + j + 1);
                tbl[5].b[i][j] = 8'(4 * i + j + 1);
                tbl[4].c[i][j] = 32'(4 * i + j + 1);
                tbl[5].c[i][j] = 32'(2 * (4 * i + j + 1));
                tbl[6].c[i][j] = 32'(i + 1);
            end
        for (int i = 0; i < 4; i++) begin
            tbl[6].a[i][0] = 8'(i + 1);
            tbl[6].b[0][i] = 8'sd1;
        end

        repeat (3) @(negedge clk);
        chk("reset done", longint'(done), 0);
        chk("reset result_valid", longint'(result_valid), 0);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) exp_c[i][j] = 0;
        check_result("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < NTBL; v++) begin
            for (int i = 0; i < ROWS; i++)
                for (int s = 0; s < 16; s++) cur_a[i][s] = (s < 4) ? int'($signed(tbl[v].a[i][s])) : 0;
            for (int s = 0; s < 16; s++)
                for (int j = 0; j < COLS; j++) cur_b[s][j] = (s < 4) ? int'($signed(tbl[v].b[s][j])) : 0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) exp_c[i][j] = int'($signed(tbl[v].c[i][j]));
            run_op($sformatf("tbl%0d", v), int'(tbl[v].k), int'(tbl[v].pre), v > 0, v == 2);
        end

        // Reset during DRAIN: result from the previous run must be wiped, no completion.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < ROWS; i++) acc_col[i] = 8'(s + i + 1);
            for (int j = 0; j < COLS; j++) wet_row[j] = 8'(j - s);
            acc_valid = 1'b1;
            wet_valid = 1'b1;
            @(negedge clk);
        end
        acc_valid = 1'b0;
        wet_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset done", longint'(done), 0);
        chk("midreset result_valid", longint'(result_valid), 0);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) exp_c[i][j] = 0;
        check_result("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midreset no_done", longint'(done), 0);
        @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            int k;
            k = int'($urandom_range(1, 12));
            for (int i = 0; i < ROWS; i++)
                for (int s = 0; s < 16; s++) cur_a[i][s] = int'($urandom_range(0, 255)) - 128;
            for (int s = 0; s < 16; s++)
                for (int j = 0; j < COLS; j++) cur_b[s][j] = int'($urandom_range(0, 255)) - 128;
            model(k);
            run_op($sformatf("rand%0d", r), k, int'($urandom_range(0, 2)), r > 0, r[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
